// File: rtl/seq_det_ctrl_if.sv
// Configuration handshake bundle for seq_det_ctrl.
//   master : host side, drives cfg_valid/cfg_pattern/cfg_len/cfg_overlap/cfg_target,
//            receives cfg_ready
//   slave  : controller side, the reverse
// cfg_pattern[len-1] is the first serial bit expected, cfg_pattern[0] the last.
interface seq_det_ctrl_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output cfg_ready
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run-time programmable Moore serial sequence detector controller.
// Holds pattern/length/overlap/target, arms on start, shifts x every RUN cycle,
// pulses z one cycle after the final pattern bit and counts matches.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cfg           seq_det_ctrl_if.slave configuration handshake (accepted in IDLE only)
//   start, abort  arm detection / force return to IDLE
//   x             serial input bit
//   z             registered match pulse
//   busy, done    high in RUN / one-cycle pulse in DONE
//   match_cnt     matches in the current run (saturating)
//   timeout       one-cycle pulse on RUN idle timeout
// Optional feature: define SEQ_CTRL_TIMEOUT_EN to enable the RUN idle watchdog;
// otherwise timeout is tied to 0 and RUN lasts until target or abort.
module seq_det_ctrl #(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                rst,
    seq_det_ctrl_if.slave       cfg,
    input  logic                start,
    input  logic                abort,
    input  logic                x,
    output logic                z,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    match_cnt,
    output logic                timeout
);
    localparam int LEN_W = $clog2(PAT_W) + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             overlap;
    logic [CNT_W-1:0] target;
    logic [PAT_W-1:0] hist;
    logic [LEN_W-1:0] fill;
    // Set by the match that reaches target: RUN holds one more cycle (z/busy
    // visible together) before DONE, and x is ignored during that cycle.
    logic             fin;

    logic [PAT_W-1:0] hist_nxt;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hit;

`ifdef SEQ_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] tcnt;
    logic            timeout_r;
    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    // State decodes of the registered FSM state.
    assign cfg.cfg_ready = (state == IDLE);
    assign busy          = (state == RUN);
    assign done          = (state == DONE);

    // Match is evaluated on the history as it will be after this cycle's shift.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len));
        end
        hist_nxt = {hist[PAT_W-2:0], x};
        fill_nxt = (fill < LEN_MAX) ? fill + 1'b1 : fill;
        hit      = (fill_nxt >= len) && ((hist_nxt & mask) == (pattern & mask));
        cnt_nxt  = (match_cnt == '1) ? match_cnt : match_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pattern   <= '0;
            len       <= LEN_MAX;
            overlap   <= 1'b0;
            target    <= '0;
            hist      <= '0;
            fill      <= '0;
            fin       <= 1'b0;
            match_cnt <= '0;
            z         <= 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
            tcnt      <= '0;
            timeout_r <= 1'b0;
`endif
        end else begin
            z <= 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
            // Capture happens before the start decision, so a same-cycle
            // cfg_valid + start runs with the new configuration.
            if (cfg.cfg_valid && state == IDLE) begin
                pattern <= cfg.cfg_pattern;
                len     <= (cfg.cfg_len == '0 || cfg.cfg_len > LEN_MAX) ? LEN_MAX : cfg.cfg_len;
                overlap <= cfg.cfg_overlap;
                target  <= cfg.cfg_target;
            end

            if (abort) begin
                state <= IDLE;
                fill  <= '0;
                fin   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= RUN;
                            match_cnt <= '0;
                            hist      <= '0;
                            fill      <= '0;
                            fin       <= 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
                            tcnt      <= '0;
`endif
                        end
                    end
                    RUN: begin
                        if (fin) begin
                            state <= DONE;
                            fin   <= 1'b0;
                        end else begin
                            hist <= hist_nxt;
                            if (hit) begin
                                z         <= 1'b1;
                                match_cnt <= cnt_nxt;
                                fill      <= overlap ? fill_nxt : '0;
                                if (target != '0 && cnt_nxt == target) begin
                                    fin <= 1'b1;
                                end
`ifdef SEQ_CTRL_TIMEOUT_EN
                                tcnt <= '0;
`endif
                            end else begin
                                fill <= fill_nxt;
`ifdef SEQ_CTRL_TIMEOUT_EN
                                if (tcnt == TO_W'(TIMEOUT - 1)) begin
                                    state     <= IDLE;
                                    timeout_r <= 1'b1;
                                end else begin
                                    tcnt <= tcnt + 1'b1;
                                end
`endif
                            end
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Run-time configurable controller for the team's serial Moore sequence detectors. It generalises the fixed-pattern detector family: it holds a programmable pattern, length, overlap mode and match target, and arms and disarms matching on the serial input `x`. It counts detections and reports completion. It sits between a host-side configuration/control interface and the serial bit stream.

## Interface
- `PAT_W`, default 4: maximum pattern length in bits.
- `CNT_W`, default 8: width of match counter and target.
- `TIMEOUT`, default 1000: RUN-state idle limit in cycles, used only with `SEQ_CTRL_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cfg_valid`  in  1  configuration offer.
- `cfg_ready`  out  1  high only in IDLE; a transfer occurs when `cfg_valid & cfg_ready` at a clock edge.
- `cfg_pattern`  in  PAT_W  pattern; `cfg_pattern[len-1]` is the first bit received and `cfg_pattern[0]` the last.
- `cfg_len`  in  $clog2(PAT_W)+1  pattern length.
- `cfg_overlap`  in  1  1 = overlapping detection, 0 = non-overlapping.
- `cfg_target`  in  CNT_W  match count that ends the run; 0 = free-run.
- `start`  in  1  arm detection.
- `abort`  in  1  force return to IDLE.
- `x`  in  1  serial input bit, sampled every cycle in RUN.
- `z`  out  1  registered match pulse.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse, high in DONE.
- `match_cnt`  out  CNT_W  matches counted in the current run.
- `timeout`  out  1  one-cycle pulse on timeout; constant 0 without the macro.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `cfg_ready`=1, `z`=0, `busy`=0, `done`=0, `match_cnt`=0, `timeout`=0.
- Reset values of the config registers: pattern=0, len=PAT_W, overlap=0, target=0.
- Config capture in IDLE: on a handshake, latch pattern, len, overlap and target.
- `cfg_len` of 0 or greater than PAT_W is stored as PAT_W.
- Configuration offered outside IDLE is not accepted, because `cfg_ready`=0.
- IDLE to RUN on `start`. Entering RUN clears `match_cnt`, the history shift register and the fill count.
- If `cfg_valid` and `start` are both high in the same IDLE cycle, the run uses the newly captured configuration.
- RUN shifting: each cycle, shift `x` into history bit 0 and increment the fill count, saturating at PAT_W.
- Match condition: fill count ≥ len and history[len-1:0] == pattern[len-1:0], evaluated on the post-shift history.
- On a match:
  - `z` is set for one cycle.
  - `match_cnt` increments, saturating at all-ones.
  - If overlap=0, the fill count clears, so the next match needs len fresh bits.
  - If overlap=1, the history is kept.
- RUN to DONE when a match brings `match_cnt` equal to a nonzero target.
- DONE to IDLE unconditionally after one cycle. `match_cnt` holds its value until the next `start`.
- `abort` in any state returns to IDLE on the next edge. It clears `z` and the fill count and keeps `match_cnt`.
- Priority: `abort` > match/target > `start`. `start` is ignored in RUN and DONE.
- Reset asserted mid-run returns to IDLE immediately and restores all reset values.

## Timing
- `z` is high for the cycle after the edge that samples the final pattern bit: one-cycle latency, Moore-registered.
- The target match and `done` are staggered by one cycle: `z` and `busy` are high in the cycle where `match_cnt` reaches target, and `done` follows in the next cycle.
- `busy` is high from the edge after `start` until the edge after the final match.
- `cfg_ready` drops on the edge that enters RUN.

## Configuration
- Macro: `SEQ_CTRL_TIMEOUT_EN`.
- Defined:
  - A cycle counter runs in RUN and resets to 0 on every match.
  - When it reaches TIMEOUT with no match, the FSM goes to IDLE and `timeout` pulses for one cycle.
  - `done` is not asserted on a timeout exit.
- Undefined: no counter is present, `timeout` is tied to 0, and RUN lasts until target or abort.

## Test plan
- Reset mid-run:
  - Assert `rst` during RUN.
  - Expect IDLE immediately, `cfg_ready`=1, and `z`, `busy`, `done`, `match_cnt` = 0.
- Non-overlapping 1101:
  - Configure pattern 4'b1101, len 4, overlap 0, target 0, then `start`.
  - Stream `x` = 1,1,0,1,1,0,1.
  - Expect exactly one `z` pulse, after the 4th bit, and `match_cnt`=1.
- Overlapping 1101:
  - Same stream with overlap=1.
  - Expect `z` pulses after bits 4 and 7, and `match_cnt`=2.
- Target completion:
  - overlap=1, target=2, same stream.
  - Expect `done` pulse the cycle after the second `z`, then IDLE, `busy`=0, `match_cnt` held at 2.
- Abort and config rules:
  - `abort` asserted together with a match cycle: the FSM goes to IDLE, and the match's `z` does not appear.
  - A `cfg_valid` offered in RUN is not accepted.
  - `cfg_len`=0 behaves as len=4.
- Timeout, with the macro defined and TIMEOUT=20:
  - Stream all zeros.
  - Expect a `timeout` pulse at cycle 20 of RUN, `done`=0, and FSM in IDLE.
